// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: control-word layout,
// ALU op codes, canned control words and a register-dependency helper.
package mips_pkg;

  localparam int CTRL_W = 8;

  // Bit positions inside the 8-bit control word.
  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUOP_LSB = 0;

  // ALU operation codes carried in ctrl[2:0].
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  // Control words produced by the ID decoder for the main instruction classes.
  localparam logic [CTRL_W-1:0] CW_RTYPE = 8'hC0;
  localparam logic [CTRL_W-1:0] CW_LW    = 8'h68;
  localparam logic [CTRL_W-1:0] CW_SW    = 8'h30;
  localparam logic [CTRL_W-1:0] CW_BEQ   = 8'h01;
  localparam logic [CTRL_W-1:0] CW_ADDI  = 8'h60;

  // True when a producer writing dst feeds the ID instruction. $0 never counts.
  function automatic logic hazard_match(
    input logic [4:0] dst,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    hazard_match = (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational hazard detection for the ID/EX boundary: load-use and the
// two data hazards of a branch that compares its operands in ID.
module hazard_detect
  import mips_pkg::*;
(
  input  logic       i_id_regdst,
  input  logic       i_id_memwrite,
  input  logic       i_id_branch,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_ex_memtoreg,
  input  logic       i_ex_regwrite,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_ex_wreg,
  input  logic       i_mem_memtoreg,
  input  logic [4:0] i_mem_wreg,
  output logic       o_stall
);

  logic w_uses_rt;
  logic w_load_use;
  logic w_branch_ex;
  logic w_branch_mem;

  // rs is read by every instruction; rt only by R-type, stores and branches.
  assign w_uses_rt = i_id_regdst | i_id_memwrite | i_id_branch;

  // Evaluate each hazard class and combine them into one stall request.
  always_comb begin
    w_load_use   = i_ex_memtoreg & hazard_match(i_ex_rt, i_id_rs, i_id_rt, w_uses_rt);
    w_branch_ex  = i_id_branch & i_ex_regwrite
                   & hazard_match(i_ex_wreg, i_id_rs, i_id_rt, w_uses_rt);
    w_branch_mem = i_id_branch & i_mem_memtoreg
                   & hazard_match(i_mem_wreg, i_id_rs, i_id_rt, w_uses_rt);
    o_stall      = w_load_use | w_branch_ex | w_branch_mem;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated hazard detection. Inserts a bubble
// while a hazard holds, gates the ID branch decision, and counts stall and
// flush events in saturating counters.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              branch_id,
  input  logic              pc_src_id,
  input  logic [4:0]        rs_id,
  input  logic [4:0]        rt_id,
  input  logic [4:0]        rd_id,
  input  logic [4:0]        shamt_id,
  input  logic [31:0]       rdata1_id,
  input  logic [31:0]       rdata2_id,
  input  logic [31:0]       imm_id,
  input  logic              memtoreg_mem,
  input  logic [4:0]        wreg_mem,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              valid_ex,
  output logic [4:0]        rs_ex,
  output logic [4:0]        rt_ex,
  output logic [4:0]        rd_ex,
  output logic [4:0]        shamt_ex,
  output logic [31:0]       rdata1_ex,
  output logic [31:0]       rdata2_ex,
  output logic [31:0]       imm_ex,
  output logic [4:0]        wreg_ex,
  output logic              stall,
  output logic              pc_src,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CTRL_W-1:0] r_ctrl_ex;
  logic              r_valid_ex;
  logic [4:0]        r_rs_ex, r_rt_ex, r_rd_ex, r_shamt_ex;
  logic [31:0]       r_rdata1_ex, r_rdata2_ex, r_imm_ex;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  logic [4:0]        w_wreg_ex;
  logic              w_stall;
  logic              w_pc_src;

  assign w_wreg_ex = r_ctrl_ex[CTRL_REGDST] ? r_rd_ex : r_rt_ex;

  hazard_detect u_hazard_detect (
    .i_id_regdst    (ctrl_id[CTRL_REGDST]),
    .i_id_memwrite  (ctrl_id[CTRL_MEMWRITE]),
    .i_id_branch    (branch_id),
    .i_id_rs        (rs_id),
    .i_id_rt        (rt_id),
    .i_ex_memtoreg  (r_ctrl_ex[CTRL_MEMTOREG]),
    .i_ex_regwrite  (r_ctrl_ex[CTRL_REGWRITE]),
    .i_ex_rt        (r_rt_ex),
    .i_ex_wreg      (w_wreg_ex),
    .i_mem_memtoreg (memtoreg_mem),
    .i_mem_wreg     (wreg_mem),
    .o_stall        (w_stall)
  );

  // A stalled branch compares stale operands, so its decision is suppressed.
  assign w_pc_src = pc_src_id & ~w_stall;

  // EX register bank: bubble on stall (data fields simply hold), else capture ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_ex   <= 8'h00;
      r_valid_ex  <= 1'b0;
      r_rs_ex     <= 5'd0;
      r_rt_ex     <= 5'd0;
      r_rd_ex     <= 5'd0;
      r_shamt_ex  <= 5'd0;
      r_rdata1_ex <= 32'd0;
      r_rdata2_ex <= 32'd0;
      r_imm_ex    <= 32'd0;
    end else if (w_stall) begin
      r_ctrl_ex  <= 8'h00;
      r_valid_ex <= 1'b0;
    end else begin
      r_ctrl_ex   <= ctrl_id;
      r_valid_ex  <= 1'b1;
      r_rs_ex     <= rs_id;
      r_rt_ex     <= rt_id;
      r_rd_ex     <= rd_id;
      r_shamt_ex  <= shamt_id;
      r_rdata1_ex <= rdata1_id;
      r_rdata2_ex <= rdata2_id;
      r_imm_ex    <= imm_id;
    end
  end

  // Saturating event counters for stalls and IF/ID flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_pc_src && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign ctrl_ex    = r_ctrl_ex;
  assign valid_ex   = r_valid_ex;
  assign rs_ex      = r_rs_ex;
  assign rt_ex      = r_rt_ex;
  assign rd_ex      = r_rd_ex;
  assign shamt_ex   = r_shamt_ex;
  assign rdata1_ex  = r_rdata1_ex;
  assign rdata2_ex  = r_rdata2_ex;
  assign imm_ex     = r_imm_ex;
  assign wreg_ex    = w_wreg_ex;
  assign stall      = w_stall;
  assign pc_src     = w_pc_src;
  assign flush_ifid = w_pc_src;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, randomized run against a
// behavioural model, async reset mid-stall and counter saturation.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [7:0]  ctrl_id;
  logic        branch_id, pc_src_id, memtoreg_mem;
  logic [4:0]  rs_id, rt_id, rd_id, shamt_id, wreg_mem;
  logic [31:0] rdata1_id, rdata2_id, imm_id;
  logic [7:0]  ctrl_ex;
  logic        valid_ex, stall, pc_src, flush_ifid;
  logic [4:0]  rs_ex, rt_ex, rd_ex, shamt_ex, wreg_ex;
  logic [31:0] rdata1_ex, rdata2_ex, imm_ex;
  logic [15:0] stall_cnt, flush_cnt;

  // Narrow-counter copy sharing the same inputs, for quick saturation checks.
  logic [7:0]  s_ctrl_ex;
  logic        s_valid_ex, s_stall, s_pc_src, s_flush_ifid;
  logic [4:0]  s_rs_ex, s_rt_ex, s_rd_ex, s_shamt_ex, s_wreg_ex;
  logic [31:0] s_rdata1_ex, s_rdata2_ex, s_imm_ex;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ctrl_id(ctrl_id), .branch_id(branch_id),
    .pc_src_id(pc_src_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .shamt_id(shamt_id), .rdata1_id(rdata1_id), .rdata2_id(rdata2_id),
    .imm_id(imm_id), .memtoreg_mem(memtoreg_mem), .wreg_mem(wreg_mem),
    .ctrl_ex(ctrl_ex), .valid_ex(valid_ex), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .rd_ex(rd_ex), .shamt_ex(shamt_ex), .rdata1_ex(rdata1_ex),
    .rdata2_ex(rdata2_ex), .imm_ex(imm_ex), .wreg_ex(wreg_ex), .stall(stall),
    .pc_src(pc_src), .flush_ifid(flush_ifid), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .ctrl_id(ctrl_id), .branch_id(branch_id),
    .pc_src_id(pc_src_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .shamt_id(shamt_id), .rdata1_id(rdata1_id), .rdata2_id(rdata2_id),
    .imm_id(imm_id), .memtoreg_mem(memtoreg_mem), .wreg_mem(wreg_mem),
    .ctrl_ex(s_ctrl_ex), .valid_ex(s_valid_ex), .rs_ex(s_rs_ex), .rt_ex(s_rt_ex),
    .rd_ex(s_rd_ex), .shamt_ex(s_shamt_ex), .rdata1_ex(s_rdata1_ex),
    .rdata2_ex(s_rdata2_ex), .imm_ex(s_imm_ex), .wreg_ex(s_wreg_ex), .stall(s_stall),
    .pc_src(s_pc_src), .flush_ifid(s_flush_ifid), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic br, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic pcs,
                       input logic mtr, input logic [4:0] wm);
    ctrl_id = c; branch_id = br; rs_id = s; rt_id = t; rd_id = d;
    pc_src_id = pcs; memtoreg_mem = mtr; wreg_mem = wm;
  endtask

  typedef struct {
    logic [7:0] ctrl; logic br; logic [4:0] rs, rt, rd; logic pcs; logic mtr; logic [4:0] wm;
    logic e_stall; logic e_pcs; logic e_valid; logic [7:0] e_ctrl;
  } vec_t;

  vec_t tv[14];

  // Behavioural model of what EX holds and what the counters should read.
  typedef struct {
    logic [7:0] ctrl; logic valid; logic [4:0] rs, rt, rd, sh; logic [31:0] d1, d2, im;
  } ex_t;
  ex_t m;
  int  m_stalls, m_flushes;

  // Registers a producer ahead of ID will write and that ID must wait for.
  function automatic bit model_stall();
    logic [4:0] pending[$];
    bit reads_rt;
    if (m.ctrl[3]) pending.push_back(m.rt);
    if (branch_id && m.ctrl[6]) pending.push_back(m.ctrl[7] ? m.rd : m.rt);
    if (branch_id && memtoreg_mem) pending.push_back(wreg_mem);
    reads_rt = ctrl_id[7] || ctrl_id[4] || branch_id;
    foreach (pending[k]) begin
      if (pending[k] != 5'd0 && (pending[k] == rs_id || (reads_rt && pending[k] == rt_id)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    tv[0]  = '{8'h68, 1'b0, 5'd1,  5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{8'hC0, 1'b0, 5'd2,  5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h68};
    tv[2]  = '{8'hC0, 1'b0, 5'd2,  5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[3]  = '{8'h68, 1'b0, 5'd1,  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'hC0};
    tv[4]  = '{8'hC0, 1'b0, 5'd0,  5'd0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h68};
    tv[5]  = '{8'h01, 1'b1, 5'd5,  5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'hC0};
    tv[6]  = '{8'h01, 1'b1, 5'd5,  5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[7]  = '{8'h68, 1'b0, 5'd1,  5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h01};
    tv[8]  = '{8'h01, 1'b1, 5'd8,  5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h68};
    tv[9]  = '{8'h01, 1'b1, 5'd8,  5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[10] = '{8'h01, 1'b1, 5'd8,  5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[11] = '{8'h68, 1'b0, 5'd1,  5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h01};
    tv[12] = '{8'h30, 1'b0, 5'd10, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h68};
    tv[13] = '{8'h30, 1'b0, 5'd10, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset state.
    rst = 1'b1;
    drive(8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    shamt_id = 5'd0; rdata1_id = 32'd0; rdata2_id = 32'd0; imm_id = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl_ex", 64'(ctrl_ex), 64'h00);
    chk("rst_valid_ex", 64'(valid_ex), 64'h0);
    chk("rst_fields", 64'({rs_ex, rt_ex, rd_ex, shamt_ex}), 64'h0);
    chk("rst_data", 64'(rdata1_ex | rdata2_ex | imm_ex), 64'h0);
    chk("rst_counters", 64'({stall_cnt, flush_cnt}), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    rst = 1'b0;

    // Directed vector table: one ID instruction per cycle.
    for (int i = 0; i < 14; i++) begin
      drive(tv[i].ctrl, tv[i].br, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].pcs, tv[i].mtr, tv[i].wm);
      rdata1_id = 32'h1000 + 32'(i);
      #3;
      chk($sformatf("tv%0d_stall", i), 64'(stall), 64'(tv[i].e_stall));
      chk($sformatf("tv%0d_pc_src", i), 64'(pc_src), 64'(tv[i].e_pcs));
      chk($sformatf("tv%0d_flush_ifid", i), 64'(flush_ifid), 64'(tv[i].e_pcs));
      chk($sformatf("tv%0d_ctrl_ex", i), 64'(ctrl_ex), 64'(tv[i].e_ctrl));
      chk($sformatf("tv%0d_valid_ex", i), 64'(valid_ex), 64'(tv[i].e_valid));
      if (i == 3) chk("tv3_rs_rd_ex", 64'({rs_ex, rd_ex}), 64'({5'd2, 5'd4}));
      @(posedge clk);
      #1;
    end
    chk("tv_stall_cnt", 64'(stall_cnt), 64'd5);
    chk("tv_flush_cnt", 64'(flush_cnt), 64'd2);

    // Randomized run against the model, starting from an async reset pulse.
    rst = 1'b1; #1; rst = 1'b0;
    m = '{8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0};
    m_stalls = 0; m_flushes = 0;
    for (int n = 0; n < 400; n++) begin
      logic [7:0] cws[6];
      bit exp_st;
      cws[0] = CW_RTYPE; cws[1] = CW_LW; cws[2] = CW_SW; cws[3] = CW_BEQ; cws[4] = CW_ADDI;
      cws[5] = 8'($urandom);
      ctrl_id      = cws[$urandom_range(0, 5)];
      branch_id    = (ctrl_id == CW_BEQ) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
      pc_src_id    = branch_id & 1'($urandom);
      rs_id        = 5'($urandom_range(0, 3));
      rt_id        = 5'($urandom_range(0, 3));
      rd_id        = 5'($urandom_range(0, 3));
      shamt_id     = 5'($urandom);
      rdata1_id    = $urandom; rdata2_id = $urandom; imm_id = $urandom;
      memtoreg_mem = 1'($urandom);
      wreg_mem     = 5'($urandom_range(0, 3));
      #3;
      exp_st = model_stall();
      chk("rnd_stall", 64'(stall), 64'(exp_st));
      chk("rnd_pc_src", 64'(pc_src), 64'(pc_src_id && !exp_st));
      chk("rnd_flush_ifid", 64'(flush_ifid), 64'(pc_src_id && !exp_st));
      chk("rnd_wreg_ex", 64'(wreg_ex), 64'(m.ctrl[7] ? m.rd : m.rt));
      chk("rnd_ctrl_valid", 64'({ctrl_ex, valid_ex}), 64'({m.ctrl, m.valid}));
      if (m.valid)
        chk("rnd_payload", 64'({rs_ex, rt_ex, rd_ex, shamt_ex, rdata1_ex[3:0]} ^ {rdata2_ex, imm_ex}),
            64'({m.rs, m.rt, m.rd, m.sh, m.d1[3:0]} ^ {m.d2, m.im}));
      chk("rnd_counters", 64'({stall_cnt, flush_cnt}),
          64'({16'(m_stalls > 65535 ? 65535 : m_stalls), 16'(m_flushes > 65535 ? 65535 : m_flushes)}));
      @(posedge clk);
      if (exp_st) begin
        m.ctrl = 8'h00; m.valid = 1'b0; m_stalls++;
      end else begin
        m = '{ctrl_id, 1'b1, rs_id, rt_id, rd_id, shamt_id, rdata1_id, rdata2_id, imm_id};
        if (pc_src_id) m_flushes++;
      end
      #1;
    end

    // Async reset asserted in the middle of a load-use stall.
    drive(8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    drive(CW_LW, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    drive(CW_RTYPE, 1'b0, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0);
    #1;
    chk("ar_stall_before", 64'(stall), 64'h1);
    chk("ar_counts_nonzero", 64'((stall_cnt != 16'd0) && (flush_cnt != 16'd0)), 64'h1);
    rst = 1'b1;
    #1;
    chk("ar_ctrl_valid", 64'({ctrl_ex, valid_ex}), 64'h0);
    chk("ar_counters", 64'({stall_cnt, flush_cnt}), 64'h0);
    chk("ar_stall_released", 64'(stall), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_capture", 64'({ctrl_ex, valid_ex, rs_ex}), 64'({8'hC0, 1'b1, 5'd2}));

    // Counter saturation: an unbroken branch-MEM stall, then a run of flushes.
    rst = 1'b1; #1; rst = 1'b0;
    drive(CW_BEQ, 1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b1, 5'd3);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_stall_still", 64'(stall), 64'h1);
    chk("sat_stall_cnt16", 64'(stall_cnt), 64'hFFFF);
    chk("sat_stall_cnt3", 64'(s_stall_cnt), 64'h7);
    chk("sat_no_flush", 64'(flush_cnt), 64'h0);
    drive(CW_BEQ, 1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 5'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_flush_cnt16", 64'(flush_cnt), 64'd10);
    chk("sat_flush_cnt3", 64'(s_flush_cnt), 64'h7);
    chk("sat_stall_hold", 64'(stall_cnt), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
